// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a 32-bit word stream into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit big-endian bit length,
// and hands blocks to the hash core one at a time, gated on core ready.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_FILL     | accepting message beats into the block buffer
// S_ISSUE    | block complete; pulse init/next once the core is ready
// S_WAIT_ACK | one dead cycle while the core drops ready
// S_WAIT_RDY | core hashing; on ready clear buffer, finish or continue
// S_PAD      | build extra block: 0x80 in word 0, length in words 14-15
// S_LENBLK   | build extra block: zeros, length in words 14-15
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_nbytes,
  output logic [511:0] sha_block,
  output logic         sha_init,
  output logic         sha_next,
  input  logic         sha_ready,
  output logic         busy,
  output logic         msg_done
);

  typedef enum logic [2:0] {
    S_FILL, S_ISSUE, S_WAIT_ACK, S_WAIT_RDY, S_PAD, S_LENBLK
  } state_t;

  typedef enum logic [1:0] {N_NONE, N_PAD, N_LENBLK} need_t;

  state_t             r_state;
  state_t             w_state_nxt;
  // word 0 of the block lives in r_words[15] so the packed vector maps
  // straight onto sha_block with word 0 at [511:480]
  logic [15:0][31:0]  r_words;
  logic [3:0]         r_wptr;
  logic [LEN_W-1:0]   r_bitlen;
  logic               r_final;
  need_t              r_need;
  logic               r_first;
  logic               r_busy;
  logic               r_msg_ready;

  logic               w_accept;
  logic [LEN_W-1:0]   w_bitlen_nxt;
  logic [63:0]        w_len_cur;
  logic [63:0]        w_len_nxt;
  logic [3:0]         w_idx;
  logic [3:0]         w_idx1;
  logic [6:0]         w_pad_pos;
  logic               w_fits;
  logic               w_wrap;
  logic               w_full;
  logic [31:0]        w_word;

  assign w_accept     = msg_valid & r_msg_ready;
  assign w_bitlen_nxt = r_bitlen + LEN_W'({msg_nbytes, 3'b000});
  assign w_len_cur    = 64'(r_bitlen);
  assign w_len_nxt    = 64'(w_bitlen_nxt);
  assign w_idx        = 4'd15 - r_wptr;
  assign w_idx1       = w_idx - 4'd1;
  // byte offset of the 0x80 marker; it and everything before must fit in 56 bytes
  assign w_pad_pos    = 7'({r_wptr, 2'b00}) + 7'(msg_nbytes);
  assign w_fits       = (w_pad_pos <= 7'd55);
  assign w_wrap       = (r_wptr == 4'd15);
  assign w_full       = msg_nbytes[2];

  assign sha_block    = r_words;
  assign msg_ready    = r_msg_ready;
  assign busy         = r_busy;

  // last-beat word: keep valid bytes, drop the marker right after them
  always_comb begin
    w_word = msg_data;
    case (msg_nbytes)
      3'd0:    w_word = 32'h8000_0000;
      3'd1:    w_word = {msg_data[31:24], 8'h80, 16'h0000};
      3'd2:    w_word = {msg_data[31:16], 8'h80, 8'h00};
      3'd3:    w_word = {msg_data[31:8], 8'h80};
      default: w_word = msg_data;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FILL;
    else      r_state <= w_state_nxt;
  end

  // next-state and core handshake pulses
  always_comb begin
    w_state_nxt = r_state;
    sha_init    = 1'b0;
    sha_next    = 1'b0;
    msg_done    = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept && (msg_last || w_wrap)) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (sha_ready) begin
          w_state_nxt = S_WAIT_ACK;
          sha_init    = r_first;
          sha_next    = ~r_first;
        end
      end
      S_WAIT_ACK: w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (sha_ready) begin
          if (r_final) begin
            w_state_nxt = S_FILL;
            msg_done    = 1'b1;
          end else begin
            case (r_need)
              N_PAD:    w_state_nxt = S_PAD;
              N_LENBLK: w_state_nxt = S_LENBLK;
              default:  w_state_nxt = S_FILL;
            endcase
          end
        end
      end
      S_PAD:    w_state_nxt = S_ISSUE;
      S_LENBLK: w_state_nxt = S_ISSUE;
      default:  w_state_nxt = S_FILL;
    endcase
  end

  // block buffer, counters and message bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_words     <= '0;
      r_wptr      <= '0;
      r_bitlen    <= '0;
      r_final     <= 1'b0;
      r_need      <= N_NONE;
      r_first     <= 1'b1;
      r_busy      <= 1'b0;
      r_msg_ready <= 1'b0;
    end else begin
      r_msg_ready <= (w_state_nxt == S_FILL);
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_bitlen <= w_bitlen_nxt;
            r_wptr   <= r_wptr + 4'd1;
            if (!msg_last) begin
              r_words[w_idx] <= msg_data;
            end else begin
              r_words[w_idx] <= w_word;
              if (w_full && w_wrap) begin
                r_need <= N_PAD;
              end else begin
                if (w_full) r_words[w_idx1] <= 32'h8000_0000;
                if (w_fits) begin
                  r_words[1] <= w_len_nxt[63:32];
                  r_words[0] <= w_len_nxt[31:0];
                  r_final    <= 1'b1;
                end else begin
                  r_need <= N_LENBLK;
                end
              end
            end
          end
        end
        S_ISSUE: begin
          if (sha_ready) r_first <= 1'b0;
        end
        S_WAIT_RDY: begin
          if (sha_ready) begin
            r_words <= '0;
            r_wptr  <= '0;
            if (r_final) begin
              r_final  <= 1'b0;
              r_busy   <= 1'b0;
              r_bitlen <= '0;
              r_first  <= 1'b1;
              r_need   <= N_NONE;
            end
          end
        end
        S_PAD: begin
          r_words[15] <= 32'h8000_0000;
          r_words[1]  <= w_len_cur[63:32];
          r_words[0]  <= w_len_cur[31:0];
          r_final     <= 1'b1;
          r_need      <= N_NONE;
        end
        S_LENBLK: begin
          r_words[1] <= w_len_cur[63:32];
          r_words[0] <= w_len_cur[31:0];
          r_final    <= 1'b1;
          r_need     <= N_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule
